// File: rtl/pipe_pkg.sv
// Shared types and helpers for the RV32 inter-stage pipeline buffer.
package pipe_pkg;

  localparam int unsigned INST_W   = 32;
  localparam int unsigned PC_W     = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } pipe_state_t;

  // Increment val, holding at the all-ones value of a width-bit counter (width <= 32).
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_v) ? max_v : (val + 32'd1);
  endfunction

endpackage

// File: rtl/pipe_payload_slot.sv
// One held pipeline entry {inst, pc, data, ctrl}; reset and clear load the bubble value.
module pipe_payload_slot
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CTRL_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              ld_i,
  input  logic [INST_W-1:0] inst_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic [INST_W-1:0] inst_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic [INST_W-1:0] inst_q;
  logic [PC_W-1:0]   pc_q;
  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_q <= NOP_INST;
      pc_q   <= '0;
      data_q <= '0;
      ctrl_q <= '0;
    end else if (clr_i) begin
      inst_q <= NOP_INST;
      pc_q   <= '0;
      data_q <= '0;
      ctrl_q <= '0;
    end else if (ld_i) begin
      inst_q <= inst_i;
      pc_q   <= pc_i;
      data_q <= data_i;
      ctrl_q <= ctrl_i;
    end
  end

  assign inst_o = inst_q;
  assign pc_o   = pc_q;
  assign data_o = data_q;
  assign ctrl_o = ctrl_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/ready handshake, optional 2-entry skid,
// flush-to-bubble and saturating stall/bubble counters.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned CTRL_W  = 6,
  parameter int unsigned SKID_EN = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] in_inst,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] out_inst,
  output logic [PC_W-1:0]   out_pc,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  pipe_state_t state_q, state_d;
  logic        in_xfer, out_xfer;
  logic        head_ld, skid_ld;

  logic [INST_W-1:0] head_inst, skid_inst, head_src_inst;
  logic [PC_W-1:0]   head_pc,   skid_pc,   head_src_pc;
  logic [DATA_W-1:0] head_data, skid_data, head_src_data;
  logic [CTRL_W-1:0] head_ctrl, skid_ctrl, head_src_ctrl;

  logic [CNT_W-1:0] stall_q, stall_d, bubble_q, bubble_d;

  assign out_valid = (state_q != PS_EMPTY);
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;

  // Next state and slot load enables; flush overrides every transfer.
  always_comb begin
    state_d = state_q;
    head_ld = 1'b0;
    skid_ld = 1'b0;
    if (flush) begin
      state_d = PS_EMPTY;
    end else begin
      unique case (state_q)
        PS_EMPTY: begin
          if (in_xfer) begin
            state_d = PS_ONE;
            head_ld = 1'b1;
          end
        end
        PS_ONE: begin
          if (in_xfer && out_xfer) begin
            head_ld = 1'b1;
          end else if (in_xfer && (SKID_EN != 0)) begin
            state_d = PS_TWO;
            skid_ld = 1'b1;
          end else if (out_xfer) begin
            state_d = PS_EMPTY;
          end
        end
        PS_TWO: begin
          if (out_xfer) begin
            state_d = PS_ONE;
            head_ld = 1'b1;
          end
        end
        default: state_d = PS_EMPTY;
      endcase
    end
  end

  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (out_valid && !out_ready) stall_d = CNT_W'(sat_inc(32'(stall_q), CNT_W));
    if (!out_valid) bubble_d = CNT_W'(sat_inc(32'(bubble_q), CNT_W));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= PS_EMPTY;
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      state_q  <= state_d;
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

  // In TWO the head refills from the skid slot, otherwise from the input.
  always_comb begin
    head_src_inst = in_inst;
    head_src_pc   = in_pc;
    head_src_data = in_data;
    head_src_ctrl = in_ctrl;
    if (state_q == PS_TWO) begin
      head_src_inst = skid_inst;
      head_src_pc   = skid_pc;
      head_src_data = skid_data;
      head_src_ctrl = skid_ctrl;
    end
  end

  pipe_payload_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_head (
    .clk    (clk),
    .reset  (reset),
    .clr_i  (flush),
    .ld_i   (head_ld),
    .inst_i (head_src_inst),
    .pc_i   (head_src_pc),
    .data_i (head_src_data),
    .ctrl_i (head_src_ctrl),
    .inst_o (head_inst),
    .pc_o   (head_pc),
    .data_o (head_data),
    .ctrl_o (head_ctrl)
  );

  if (SKID_EN != 0) begin : g_skid
    pipe_payload_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (flush),
      .ld_i   (skid_ld),
      .inst_i (in_inst),
      .pc_i   (in_pc),
      .data_i (in_data),
      .ctrl_i (in_ctrl),
      .inst_o (skid_inst),
      .pc_o   (skid_pc),
      .data_o (skid_data),
      .ctrl_o (skid_ctrl)
    );
    // Registered ready: depends only on state, never on out_ready.
    assign in_ready = ~reset & (state_q != PS_TWO);
  end else begin : g_single
    assign skid_inst = NOP_INST;
    assign skid_pc   = '0;
    assign skid_data = '0;
    assign skid_ctrl = '0;
    assign in_ready  = ~reset & (~out_valid | out_ready);
  end

  assign out_inst   = out_valid ? head_inst : NOP_INST;
  assign out_pc     = out_valid ? head_pc   : '0;
  assign out_data   = out_valid ? head_data : '0;
  assign out_ctrl   = out_valid ? head_ctrl : '0;
  assign occupancy  = (state_q == PS_TWO) ? 2'd2 : ((state_q == PS_ONE) ? 2'd1 : 2'd0);
  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: skid config, single-register config and a 4-bit counter config.
module tb_pipe_stage_buf;
  import pipe_pkg::*;

  localparam int unsigned DW = 64;
  localparam int unsigned CW = 6;

  typedef struct {
    logic [31:0]   inst;
    logic [31:0]   pc;
    logic [DW-1:0] data;
    logic [CW-1:0] ctrl;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // dut0: skid, 16-bit counters
  logic fl0, iv0, ir0, ov0, or0;
  logic [31:0] ii0, ip0, oi0, op0;
  logic [DW-1:0] id0, od0;
  logic [CW-1:0] ic0, oc0;
  logic [1:0] occ0;
  logic [15:0] sc0, bc0;
  // dut1: single register
  logic fl1, iv1, ir1, ov1, or1;
  logic [31:0] ii1, ip1, oi1, op1;
  logic [DW-1:0] id1, od1;
  logic [CW-1:0] ic1, oc1;
  logic [1:0] occ1;
  logic [15:0] sc1, bc1;
  // dut2: skid, 4-bit counters
  logic fl2, iv2, ir2, ov2, or2;
  logic [31:0] ii2, ip2, oi2, op2;
  logic [DW-1:0] id2, od2;
  logic [CW-1:0] ic2, oc2;
  logic [1:0] occ2;
  logic [3:0] sc2, bc2;

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .flush(fl0), .in_valid(iv0), .in_ready(ir0),
    .in_inst(ii0), .in_pc(ip0), .in_data(id0), .in_ctrl(ic0),
    .out_valid(ov0), .out_ready(or0), .out_inst(oi0), .out_pc(op0),
    .out_data(od0), .out_ctrl(oc0), .occupancy(occ0), .stall_cnt(sc0), .bubble_cnt(bc0));

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(0), .CNT_W(16)) dut1 (
    .clk(clk), .reset(reset), .flush(fl1), .in_valid(iv1), .in_ready(ir1),
    .in_inst(ii1), .in_pc(ip1), .in_data(id1), .in_ctrl(ic1),
    .out_valid(ov1), .out_ready(or1), .out_inst(oi1), .out_pc(op1),
    .out_data(od1), .out_ctrl(oc1), .occupancy(occ1), .stall_cnt(sc1), .bubble_cnt(bc1));

  pipe_stage_buf #(.DATA_W(DW), .CTRL_W(CW), .SKID_EN(1), .CNT_W(4)) dut2 (
    .clk(clk), .reset(reset), .flush(fl2), .in_valid(iv2), .in_ready(ir2),
    .in_inst(ii2), .in_pc(ip2), .in_data(id2), .in_ctrl(ic2),
    .out_valid(ov2), .out_ready(or2), .out_inst(oi2), .out_pc(op2),
    .out_data(od2), .out_ctrl(oc2), .occupancy(occ2), .stall_cnt(sc2), .bubble_cnt(bc2));

  int n_cmp = 0;
  int n_err = 0;
  ent_t q0[$];
  ent_t q1[$];
  ent_t e0, e1;

  // Scoreboard for dut0: push on accepted input, pop on delivered head, check bubble masking.
  always @(negedge clk) begin
    if (reset) begin
      q0.delete();
    end else begin
      if (ov0 && or0) begin
        n_cmp++;
        if (q0.size() == 0) begin
          n_err++;
          $display("FAIL sb0_underflow: got pc=%h with nothing expected", op0);
        end else begin
          e0 = q0.pop_front();
          if ({oi0, op0, od0, oc0} !== {e0.inst, e0.pc, e0.data, e0.ctrl}) begin
            n_err++;
            $display("FAIL sb0_entry: got inst=%h pc=%h data=%h ctrl=%h expected inst=%h pc=%h data=%h ctrl=%h",
                     oi0, op0, od0, oc0, e0.inst, e0.pc, e0.data, e0.ctrl);
          end
        end
      end
      if (!ov0) begin
        n_cmp++;
        if ({oi0, op0, od0, oc0} !== {NOP_INST, 32'd0, 64'd0, 6'd0}) begin
          n_err++;
          $display("FAIL sb0_bubble: got inst=%h pc=%h data=%h ctrl=%h expected NOP/0", oi0, op0, od0, oc0);
        end
      end
      if (fl0) q0.delete();
      else if (iv0 && ir0) q0.push_back('{ii0, ip0, id0, ic0});
    end
  end

  // Scoreboard for dut1.
  always @(negedge clk) begin
    if (reset) begin
      q1.delete();
    end else begin
      if (ov1 && or1) begin
        n_cmp++;
        if (q1.size() == 0) begin
          n_err++;
          $display("FAIL sb1_underflow: got pc=%h with nothing expected", op1);
        end else begin
          e1 = q1.pop_front();
          if ({oi1, op1, od1, oc1} !== {e1.inst, e1.pc, e1.data, e1.ctrl}) begin
            n_err++;
            $display("FAIL sb1_entry: got inst=%h pc=%h expected inst=%h pc=%h", oi1, op1, e1.inst, e1.pc);
          end
        end
      end
      if (fl1) q1.delete();
      else if (iv1 && ir1) q1.push_back('{ii1, ip1, id1, ic1});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fl0 = 0; iv0 = 0; or0 = 0; ii0 = 0; ip0 = 0; id0 = 0; ic0 = 0;
    fl1 = 0; iv1 = 0; or1 = 0; ii1 = 0; ip1 = 0; id1 = 0; ic1 = 0;
    fl2 = 0; iv2 = 0; or2 = 0; ii2 = 0; ip2 = 0; id2 = 0; ic2 = 0;
  endtask

  task automatic do_reset();
    tick();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic drive0(input logic [31:0] inst, input logic [31:0] pc, input logic [DW-1:0] data, input logic [CW-1:0] ctrl);
    iv0 = 1'b1; ii0 = inst; ip0 = pc; id0 = data; ic0 = ctrl;
  endtask

  task automatic test_reset();
    #12;
    n_cmp++; if (ov0 !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b expected 0", ov0); end
    n_cmp++; if (oi0 !== NOP_INST) begin n_err++; $display("FAIL rst_out_inst: got %h expected %h", oi0, NOP_INST); end
    n_cmp++; if (occ0 !== 2'd0) begin n_err++; $display("FAIL rst_occupancy: got %0d expected 0", occ0); end
    n_cmp++; if ({sc0, bc0} !== 32'd0) begin n_err++; $display("FAIL rst_counters: got %h expected 0", {sc0, bc0}); end
    n_cmp++; if ({ir0, ir1, ir2} !== 3'b000) begin n_err++; $display("FAIL rst_in_ready_held: got %b expected 000", {ir0, ir1, ir2}); end
    tick();
    reset = 1'b0;
    #1;
    n_cmp++; if ({ir0, ir1, ir2} !== 3'b111) begin n_err++; $display("FAIL rst_in_ready_free: got %b expected 111", {ir0, ir1, ir2}); end
  endtask

  task automatic test_bubble_count();
    do_reset();
    repeat (3) tick();
    n_cmp++; if (bc0 !== 16'd3) begin n_err++; $display("FAIL bubble_cnt0: got %0d expected 3", bc0); end
    n_cmp++; if (sc0 !== 16'd0) begin n_err++; $display("FAIL stall_cnt0_idle: got %0d expected 0", sc0); end
    n_cmp++; if (bc2 !== 4'd3) begin n_err++; $display("FAIL bubble_cnt2: got %0d expected 3", bc2); end
  endtask

  task automatic test_skid();
    do_reset();
    or0 = 1'b0;
    drive0(32'hA0A0_0001, 32'h0000_0100, 64'hAAAA_0000_1111_2222, 6'h21);
    tick();
    drive0(32'hB0B0_0002, 32'h0000_0104, 64'hBBBB_3333_4444_5555, 6'h12);
    tick();
    iv0 = 1'b0;
    #1;
    n_cmp++; if (occ0 !== 2'd2) begin n_err++; $display("FAIL skid_occupancy: got %0d expected 2", occ0); end
    n_cmp++; if (ir0 !== 1'b0) begin n_err++; $display("FAIL skid_in_ready: got %b expected 0", ir0); end
    n_cmp++; if (oi0 !== 32'hA0A0_0001) begin n_err++; $display("FAIL skid_head: got %h expected a0a00001", oi0); end
    // Refused entry must not disturb the held pair.
    drive0(32'hC0C0_0003, 32'h0000_0108, 64'h1, 6'h3);
    tick();
    iv0 = 1'b0;
    or0 = 1'b1;
    #1;
    n_cmp++; if (ir0 !== 1'b0) begin n_err++; $display("FAIL skid_ready_registered: got %b expected 0", ir0); end
    tick();
    n_cmp++; if ({occ0, oi0} !== {2'd1, 32'hB0B0_0002}) begin n_err++; $display("FAIL skid_second: got occ=%0d inst=%h expected 1/b0b00002", occ0, oi0); end
    tick();
    n_cmp++; if (occ0 !== 2'd0) begin n_err++; $display("FAIL skid_drained: got %0d expected 0", occ0); end
  endtask

  task automatic test_stream();
    int acc;
    do_reset();
    acc = 0;
    or0 = 1'b1;
    for (int i = 0; i < 100; i++) begin
      drive0($urandom, 32'h0000_1000 + 32'(4 * i), {$urandom, $urandom}, 6'($urandom));
      @(negedge clk);
      if (ir0) acc++;
      tick();
    end
    iv0 = 1'b0;
    tick();
    tick();
    n_cmp++; if (acc !== 100) begin n_err++; $display("FAIL stream_throughput: got %0d accepted expected 100", acc); end
    n_cmp++; if (sc0 !== 16'd0) begin n_err++; $display("FAIL stream_stall_cnt: got %0d expected 0", sc0); end
    n_cmp++; if (q0.size() !== 0) begin n_err++; $display("FAIL stream_drain: got %0d pending expected 0", q0.size()); end
  endtask

  task automatic test_flush();
    do_reset();
    or0 = 1'b0;
    drive0(32'hCCCC_0013, 32'h0000_2000, 64'hC, 6'h3F);
    tick();
    fl0 = 1'b1;
    drive0(32'hDDDD_0013, 32'h0000_2004, 64'hD, 6'h2A);
    tick();
    fl0 = 1'b0;
    iv0 = 1'b0;
    #1;
    n_cmp++; if ({ov0, oc0} !== {1'b0, 6'd0}) begin n_err++; $display("FAIL flush_bubble: got valid=%b ctrl=%h expected 0/00", ov0, oc0); end
    n_cmp++; if (occ0 !== 2'd0) begin n_err++; $display("FAIL flush_occupancy: got %0d expected 0", occ0); end
    n_cmp++; if (sc0 !== 16'd1) begin n_err++; $display("FAIL flush_keeps_cnt: got %0d expected 1", sc0); end
    or0 = 1'b1;
    repeat (3) tick();
    n_cmp++; if (ov0 !== 1'b0) begin n_err++; $display("FAIL flush_drop_input: got valid=%b expected 0", ov0); end
  endtask

  task automatic test_noskid_stall();
    logic [31:0] x_inst, x_pc;
    do_reset();
    x_inst = 32'h1234_5013;
    x_pc = 32'h0000_3000;
    or1 = 1'b0;
    iv1 = 1'b1; ii1 = x_inst; ip1 = x_pc; id1 = 64'hFEED_BEEF_0000_0001; ic1 = 6'h15;
    tick();
    ii1 = 32'h5678_9013; ip1 = 32'h0000_3004; id1 = 64'h2; ic1 = 6'h0A;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({oi1, op1} !== {x_inst, x_pc}) begin
        n_err++;
        $display("FAIL noskid_hold: got inst=%h pc=%h expected %h/%h", oi1, op1, x_inst, x_pc);
      end
      tick();
    end
    n_cmp++; if (sc1 !== 16'd5) begin n_err++; $display("FAIL noskid_stall_cnt: got %0d expected 5", sc1); end
    n_cmp++; if (ir1 !== 1'b0) begin n_err++; $display("FAIL noskid_in_ready: got %b expected 0", ir1); end
    or1 = 1'b1;
    tick();
    iv1 = 1'b0;
    tick();
    tick();
    n_cmp++; if ({occ1, q1.size()} !== {2'd0, 32'd0}) begin n_err++; $display("FAIL noskid_drain: got occ=%0d pending=%0d expected 0/0", occ1, q1.size()); end
  endtask

  task automatic test_saturate();
    do_reset();
    or2 = 1'b0;
    iv2 = 1'b1; ii2 = 32'h0000_0093; ip2 = 32'h0000_4000; id2 = 64'h5; ic2 = 6'h1;
    tick();
    iv2 = 1'b0;
    repeat (14) tick();
    n_cmp++; if (sc2 !== 4'd14) begin n_err++; $display("FAIL sat_count: got %0d expected 14", sc2); end
    repeat (6) tick();
    n_cmp++; if (sc2 !== 4'd15) begin n_err++; $display("FAIL sat_hold: got %0d expected 15", sc2); end
    n_cmp++; if (bc2 !== 4'd1) begin n_err++; $display("FAIL sat_bubble: got %0d expected 1", bc2); end
  endtask

  task automatic test_reset_in_two();
    do_reset();
    or0 = 1'b0;
    drive0(32'hEEEE_0013, 32'h0000_5000, 64'hE, 6'h07);
    tick();
    drive0(32'hFFFF_0013, 32'h0000_5004, 64'hF, 6'h38);
    tick();
    iv0 = 1'b0;
    tick();
    n_cmp++; if (occ0 !== 2'd2) begin n_err++; $display("FAIL rst2_setup: got occ=%0d expected 2", occ0); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++; if ({ov0, oi0, occ0} !== {1'b0, NOP_INST, 2'd0}) begin n_err++; $display("FAIL rst2_outputs: got valid=%b inst=%h occ=%0d expected 0/00000013/0", ov0, oi0, occ0); end
    n_cmp++; if ({sc0, bc0} !== 32'd0) begin n_err++; $display("FAIL rst2_counters: got stall=%0d bubble=%0d expected 0/0", sc0, bc0); end
    tick();
    reset = 1'b0;
    or0 = 1'b1;
    tick();
    n_cmp++; if (ov0 !== 1'b0) begin n_err++; $display("FAIL rst2_lost: got valid=%b expected 0", ov0); end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_bubble_count();
    test_skid();
    test_stream();
    test_flush();
    test_noskid_stall();
    test_saturate();
    test_reset_in_two();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
